// File: rtl/n1_sbus_ram.sv
// N1 stack-bus RAM target: two 16-bit stack banks behind a pipelined
// Wishbone responder with a fixed response latency and bounded queue.
module n1_sbus_ram #(
  parameter int SP_WIDTH    = 12,
  parameter int LATENCY     = 1,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                sync_rst_i,
  input  logic                sbus_cyc_i,
  input  logic                sbus_stb_i,
  input  logic                sbus_we_i,
  input  logic [SP_WIDTH-1:0] sbus_adr_i,
  input  logic [15:0]         sbus_dat_i,
  input  logic                sbus_tga_ps_i,
  input  logic                sbus_tga_rs_i,
  output logic                sbus_ack_o,
  output logic                sbus_err_o,
  output logic                sbus_rty_o,
  output logic                sbus_stall_o,
  output logic [15:0]         sbus_dat_o,
  output logic [2:0]          prb_pending_o
);

  localparam int IW    = SP_WIDTH + 1;
  localparam int DEPTH = 2 ** IW;
  localparam int AW    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [2:0] LAT = 3'(LATENCY);
  localparam logic [2:0] QD  = 3'(QUEUE_DEPTH);

  logic [15:0] mem [DEPTH];

  logic [IW-1:0] idx;
  logic          tag_ok;
  logic          accept;
  logic          due;
  logic          pop;
  logic [15:0]   rd_word;

  logic [2:0]                   pending;
  logic [QUEUE_DEPTH-1:0]       q_err;
  logic [QUEUE_DEPTH-1:0][15:0] q_dat;
  logic [QUEUE_DEPTH-1:0][2:0]  q_age;

  logic [2:0]                   n_pending;
  logic [QUEUE_DEPTH-1:0]       n_err;
  logic [QUEUE_DEPTH-1:0][15:0] n_dat;
  logic [QUEUE_DEPTH-1:0][2:0]  n_age;

  assign idx     = {sbus_tga_rs_i, sbus_adr_i};
  assign tag_ok  = sbus_tga_ps_i ^ sbus_tga_rs_i;
  assign rd_word = mem[idx];

  // stall depends only on registered occupancy, never on a same-cycle pop
  assign sbus_stall_o = (pending == QD);
  assign accept = sbus_cyc_i & sbus_stb_i & ~sbus_stall_o;

  assign due = (pending != 3'd0) && (q_age[0] == LAT);
  assign pop = due;

  assign sbus_ack_o    = due & sbus_cyc_i & ~q_err[0];
  assign sbus_err_o    = due & sbus_cyc_i & q_err[0];
  assign sbus_rty_o    = 1'b0;
  assign sbus_dat_o    = sbus_ack_o ? q_dat[0] : 16'h0000;
  assign prb_pending_o = pending;

  always_comb begin
    n_err = '0;
    n_dat = '0;
    n_age = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (!pop) begin
        n_err[i] = q_err[i];
        n_dat[i] = q_dat[i];
        n_age[i] = (q_age[i] == LAT) ? q_age[i] : q_age[i] + 3'd1;
      end else if (i + 1 < QUEUE_DEPTH) begin
        n_err[i] = q_err[AW'(i + 1)];
        n_dat[i] = q_dat[AW'(i + 1)];
        n_age[i] = (q_age[AW'(i + 1)] == LAT) ?
                   q_age[AW'(i + 1)] : q_age[AW'(i + 1)] + 3'd1;
      end
    end
    if (accept) begin
      // new entry lands just behind the surviving ones
      n_err[AW'(pending - {2'b0, pop})] = ~tag_ok;
      n_dat[AW'(pending - {2'b0, pop})] =
        (sbus_we_i | ~tag_ok) ? 16'h0000 : rd_word;
      n_age[AW'(pending - {2'b0, pop})] = 3'd1;
    end
    n_pending = pending + {2'b0, accept} - {2'b0, pop};
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      pending <= 3'd0;
      q_err   <= '0;
      q_dat   <= '0;
      q_age   <= '0;
    end else if (!sbus_cyc_i) begin
      pending <= 3'd0;
    end else begin
      pending <= n_pending;
      q_err   <= n_err;
      q_dat   <= n_dat;
      q_age   <= n_age;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!sync_rst_i && accept && sbus_we_i && tag_ok)
      mem[idx] <= sbus_dat_i;
  end

endmodule
